// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field
// positions and helpers that assemble the software-visible register images.
package cp0_exc_unit_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Exception codes; EXC_NONE marks "nothing to take"
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_NONE = 5'h1f;

    // SR field positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 10;
    localparam int unsigned SR_IM_HI = 15;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    function automatic logic [31:0] sr_pack(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL]            = exl;
        v[SR_IE]             = ie;
        return v;
    endfunction

    function automatic logic [31:0] cause_pack(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD]                  = bd;
        v[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_sync.sv
// N-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears every stage
//   d    - asynchronous input bus
//   q    - synchronised output, STAGES edges behind d
module cp0_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt responder, located in the M stage.
// Holds SR/Cause/EPC/PRId, decides whether the M-stage instruction takes an
// interrupt or exception this cycle and reports the code being taken.
// Ports:
//   clk, rst          - clock and asynchronous active-low reset
//   hwint             - asynchronous external interrupt lines
//   m_valid/m_pc/m_bd - M-stage instruction qualifier, PC and delay-slot flag
//   m_exc             - M-stage exception code (EXC_NONE when none)
//   m_eret            - M-stage instruction is eret
//   cp0_we/addr/wdata - mtc0 write port (write already gated by the handler)
//   cp0_rdata         - mfc0 read data, combinational
//   epc               - eret target, bypassing a same-cycle mtc0 EPC
//   have2handle       - take an interrupt/exception this cycle
//   m_exc_final       - code being taken, else EXC_NONE
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h4350_3330,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hwint,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc,
    input  logic        m_eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc,
    output logic        have2handle,
    output logic [4:0]  m_exc_final
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  hwint_sync;
    logic        int_req, exc_req;
    logic        sw_write, epc_write;

    cp0_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (hwint),
        .q   (hwint_sync)
    );

    assign int_req = (|(cause_ip_q & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (m_exc != EXC_NONE) & ~sr_exl_q;

    // rst gates the request so nothing is taken while the core is held in reset
    assign have2handle = rst & m_valid & (int_req | exc_req);
    assign m_exc_final = !have2handle ? EXC_NONE : (int_req ? EXC_INT : m_exc);

    // A taken exception/interrupt drops any same-cycle mtc0
    assign sw_write  = cp0_we & ~have2handle;
    assign epc_write = sw_write & (cp0_addr == CP0_EPC);

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (have2handle) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = m_exc_final;
            cause_bd_d  = m_bd;
            epc_d       = m_bd ? (m_pc - 32'd4) : m_pc;
        end else begin
            if (sw_write && (cp0_addr == CP0_SR)) begin
                sr_im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
                sr_exl_d = cp0_wdata[SR_EXL];
                sr_ie_d  = cp0_wdata[SR_IE];
            end
            if (epc_write) begin
                epc_d = cp0_wdata;
            end
            // Ordered after the SR write so eret wins over mtc0 to EXL
            if (m_valid && m_eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= hwint_sync;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_pack(sr_im_q, sr_exl_q, sr_ie_q);
            CP0_CAUSE: cp0_rdata = cause_pack(cause_bd_q, cause_ip_q, cause_exc_q);
            CP0_EPC:   cp0_rdata = epc_q;
            CP0_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = '0;
        endcase
    end

    // Bypass lets an eret right after mtc0 EPC see the new target
    assign epc = epc_write ? cp0_wdata : epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;
    import cp0_exc_unit_pkg::*;

    localparam logic [31:0] PRID_V = 32'h4350_3330;
    localparam int unsigned SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hwint;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc;
    logic        m_eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        have2handle;
    logic [4:0]  m_exc_final;

    cp0_exc_unit #(
        .PRID        (PRID_V),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hwint       (hwint),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_bd        (m_bd),
        .m_exc       (m_exc),
        .m_eret      (m_eret),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .epc         (epc),
        .have2handle (have2handle),
        .m_exc_final (m_exc_final)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register images plus a FIFO of hwint
    // samples modelling the pin-to-IP delay.
    logic [31:0] sr_m, cause_m, epc_m;
    logic [5:0]  hq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sr_m = '0;
        cause_m = '0;
        epc_m = '0;
        hq = {};
        for (int i = 0; i < int'(SYNC); i++) hq.push_back(6'd0);
    endtask

    // Check all outputs against the model for the current inputs, then
    // advance one clock and update the model.
    task automatic tick();
        logic        irq, erq, exp_h;
        logic [4:0]  exp_f;
        logic [31:0] exp_rd, exp_epc, nsr, ncause, nepc;
        logic [5:0]  ip_n;
        #1;
        if (!rst) model_clear();
        irq = ((cause_m[15:10] & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
        erq = (m_exc != EXC_NONE) && !sr_m[1];
        exp_h = rst && m_valid && (irq || erq);
        exp_f = !exp_h ? EXC_NONE : (irq ? EXC_INT : m_exc);
        case (cp0_addr)
            5'd12:   exp_rd = sr_m;
            5'd13:   exp_rd = cause_m;
            5'd14:   exp_rd = epc_m;
            5'd15:   exp_rd = PRID_V;
            default: exp_rd = 32'd0;
        endcase
        exp_epc = (cp0_we && cp0_addr == 5'd14 && !exp_h) ? cp0_wdata : epc_m;
        check("have2handle", {31'd0, have2handle}, {31'd0, exp_h});
        check("m_exc_final", {27'd0, m_exc_final}, {27'd0, exp_f});
        check("cp0_rdata", cp0_rdata, exp_rd);
        check("epc", epc, exp_epc);
        nsr = sr_m;
        ncause = cause_m;
        nepc = epc_m;
        ip_n = 6'd0;
        if (rst) begin
            hq.push_back(hwint);
            ip_n = hq.pop_front();
            if (exp_h) begin
                nsr = sr_m | 32'h2;
                ncause = (32'(m_bd) << 31) | (32'(exp_f) << 2);
                nepc = m_bd ? m_pc - 32'd4 : m_pc;
            end else begin
                if (cp0_we && cp0_addr == 5'd12) nsr = cp0_wdata & 32'h0000_FC03;
                if (cp0_we && cp0_addr == 5'd14) nepc = cp0_wdata;
                if (m_valid && m_eret) nsr = nsr & ~32'h2;
            end
            ncause = (ncause & ~32'h0000_FC00) | (32'(ip_n) << 10);
        end
        @(posedge clk);
        if (rst) begin
            sr_m = nsr;
            cause_m = ncause;
            epc_m = nepc;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_valid = 1'b0;
        m_pc = 32'd0;
        m_bd = 1'b0;
        m_exc = EXC_NONE;
        m_eret = 1'b0;
        cp0_we = 1'b0;
        cp0_addr = 5'd0;
        cp0_wdata = 32'd0;
    endtask

    logic [4:0] exc_tab[6];

    initial begin
        exc_tab[0] = EXC_NONE; exc_tab[1] = EXC_ADEL; exc_tab[2] = EXC_ADES;
        exc_tab[3] = EXC_RI;   exc_tab[4] = EXC_OV;   exc_tab[5] = EXC_NONE;
        model_clear();

        // Reset held with all interrupts asserted and a faulting instruction
        rst = 1'b0;
        idle_inputs();
        hwint = 6'h3f;
        m_valid = 1'b1;
        m_exc = EXC_OV;
        for (int i = 0; i < 4; i++) begin
            cp0_addr = 5'(12 + i);
            #1;
            check("rst_h2h", {31'd0, have2handle}, 32'd0);
            check("rst_rdata", cp0_rdata, (i == 3) ? PRID_V : 32'd0);
            tick();
        end
        rst = 1'b1;
        hwint = 6'h00;
        idle_inputs();
        tick();

        // Overflow in a delay slot
        m_valid = 1'b1; m_exc = EXC_OV; m_bd = 1'b1; m_pc = 32'h3010;
        #1;
        check("ovf_h2h", {31'd0, have2handle}, 32'd1);
        check("ovf_final", {27'd0, m_exc_final}, 32'd12);
        tick();
        idle_inputs();
        cp0_addr = CP0_EPC;   #1; check("ovf_epc", cp0_rdata, 32'h300C);   tick();
        cp0_addr = CP0_CAUSE; #1; check("ovf_cause", cp0_rdata, 32'h8000_0030); tick();
        cp0_addr = CP0_SR;    #1; check("ovf_sr", cp0_rdata, 32'h2);       tick();

        // Interrupt latency: enable IM0/IE and clear EXL, then pulse hwint[0]
        cp0_we = 1'b1; cp0_addr = CP0_SR; cp0_wdata = 32'h0000_0401;
        tick();
        idle_inputs();
        cp0_addr = CP0_SR; #1; check("int_sr", cp0_rdata, 32'h401); tick();
        m_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            hwint = (t == 0) ? 6'h01 : 6'h00;
            #1;
            check("int_lat_h2h", {31'd0, have2handle}, (t == 3) ? 32'd1 : 32'd0);
            if (t == 3) check("int_final", {27'd0, m_exc_final}, 32'd0);
            tick();
        end

        // Masked interrupt: eret, IE only, pulse every line
        idle_inputs();
        m_valid = 1'b1; m_eret = 1'b1;
        tick();
        idle_inputs();
        cp0_we = 1'b1; cp0_addr = CP0_SR; cp0_wdata = 32'h0000_0001;
        tick();
        idle_inputs();
        m_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            hwint = (t == 0) ? 6'h3f : 6'h00;
            #1;
            check("masked_h2h", {31'd0, have2handle}, 32'd0);
            tick();
        end

        // Interrupt and exception in the same cycle
        idle_inputs();
        cp0_we = 1'b1; cp0_addr = CP0_SR; cp0_wdata = 32'h0000_0401;
        tick();
        idle_inputs();
        hwint = 6'h01;
        for (int t = 0; t < 3; t++) tick();
        m_valid = 1'b1; m_exc = EXC_ADEL;
        #1;
        check("coll_h2h", {31'd0, have2handle}, 32'd1);
        check("coll_final", {27'd0, m_exc_final}, 32'd0);
        tick();
        m_exc = EXC_RI; cp0_addr = CP0_CAUSE; hwint = 6'h00;
        #1;
        check("coll_exl_h2h", {31'd0, have2handle}, 32'd0);
        check("coll_exccode", {27'd0, cp0_rdata[6:2]}, 32'd0);
        tick();

        // mtc0 EPC immediately followed by eret
        idle_inputs();
        cp0_we = 1'b1; cp0_addr = CP0_EPC; cp0_wdata = 32'h0000_3100;
        #1; check("byp_epc", epc, 32'h3100);
        tick();
        idle_inputs();
        m_valid = 1'b1; m_eret = 1'b1; cp0_addr = CP0_SR;
        #1; check("eret_epc", epc, 32'h3100);
        tick();
        idle_inputs();
        cp0_addr = CP0_SR;
        #1; check("eret_exl", {31'd0, cp0_rdata[1]}, 32'd0);
        tick();

        // SR write dropped by a same-cycle exception
        m_valid = 1'b1; m_exc = EXC_ADES; m_pc = 32'h4000;
        cp0_we = 1'b1; cp0_addr = CP0_SR; cp0_wdata = 32'd0;
        #1; check("drop_h2h", {31'd0, have2handle}, 32'd1);
        tick();
        idle_inputs();
        cp0_addr = CP0_SR;
        #1; check("drop_sr", cp0_rdata, 32'h403);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) hwint = 6'($urandom);
            m_valid = ($urandom_range(0, 3) != 0);
            m_pc = $urandom;
            m_bd = 1'($urandom);
            m_exc = exc_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) m_exc = EXC_NONE;
            m_eret = ($urandom_range(0, 5) == 0);
            cp0_we = ($urandom_range(0, 3) == 0);
            cp0_addr = 5'($urandom_range(10, 17));
            cp0_wdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt responder for the 5-stage pipelined core; sits in the M stage.
- Takes the M-stage exception code, external hardware interrupts, mtc0/mfc0 and eret.
- Owns SR/Cause/EPC/PRId and raises have2handle and m_exc_final for the pipeline handler.
- The handler consumes these to flush stages, redirect the PC to NPC_ISR, and gate writes.

Parameters:
- PRID, 32'h4350_3330, value returned for PRId reads.
- SYNC_STAGES, 2, flops in the hwint synchroniser (≥2).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- hwint  input  6  external interrupt lines, asynchronous
- m_valid  input  1  M stage holds a real instruction (not a bubble)
- m_pc  input  32  PC of the M-stage instruction
- m_bd  input  1  M-stage instruction is in a branch delay slot
- m_exc  input  5  M-stage exception code; EXC_NONE = none
- m_eret  input  1  M-stage instruction is eret
- cp0_we  input  1  mtc0 write enable, already gated by the handler
- cp0_addr  input  5  mtc0/mfc0 register number
- cp0_wdata  input  32  mtc0 data
- cp0_rdata  output  32  mfc0 data, combinational
- epc  output  32  eret target, with bypass
- have2handle  output  1  take exception/interrupt this cycle, combinational
- m_exc_final  output  5  code being taken, else EXC_NONE

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; read-only to software.
  - EPC(14): 32 bits.
  - PRId(15): constant PRID.
- Reset (rst low, async): SR=0, Cause=0, EPC=0, synchroniser flops=0. While rst is low, have2handle=0 and m_exc_final=EXC_NONE. Release on the next clk edge with rst high.
- hwint passes through SYNC_STAGES flops. Cause.IP <= synchronised hwint every cycle. Latency from pin to IP = SYNC_STAGES+1 edges.
- int_req = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
- exc_req = (m_exc != EXC_NONE) & ~SR.EXL.
- have2handle = rst & m_valid & (int_req | exc_req). Bubbles never take anything; the event waits for a valid instruction.
- Priority: interrupt over exception. m_exc_final = int_req ? EXC_INT : m_exc when have2handle, else EXC_NONE.
- On a clk edge with have2handle=1:
  - SR.EXL <= 1
  - Cause.ExcCode <= m_exc_final
  - Cause.BD <= m_bd
  - EPC <= m_bd ? m_pc-32'd4 : m_pc (raw, unaligned allowed)
- mtc0 (cp0_we & ~have2handle):
  - addr 12 writes IM, EXL, IE.
  - addr 14 writes EPC.
  - All other addresses are ignored.
- eret (m_valid & m_eret & ~have2handle): SR.EXL <= 0 on the edge.
- Simultaneous events:
  - have2handle with cp0_we: the write is dropped.
  - have2handle with eret: the exception wins and EXL stays 1.
  - eret with a write to SR.EXL: eret wins.
- Faults while SR.EXL=1 are ignored. Handler code must not fault.
- cp0_rdata: SR/Cause/EPC/PRId per cp0_addr; 0 for any other address.
- epc output: cp0_wdata when cp0_we & cp0_addr==14 & ~have2handle this cycle, else the EPC register. This covers mtc0 EPC immediately followed by eret.

Decomposition:
- Shared include cp0.h:
  - register numbers CP0_SR/CP0_CAUSE/CP0_EPC/CP0_PRID
  - EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12, EXC_NONE=5'h1f
  - SR/Cause bit-field positions
- One sub-module: cp0_sync, a parameterised N-flop synchroniser with async active-low reset.

Test Plan:
- Reset release, all registers read back:
  - Hold rst low 3 cycles with hwint=6'h3f.
  - Required: cp0_rdata for 12/13/14 = 0, PRId = PRID, have2handle=0 throughout.
- Overflow exception in a delay slot:
  - m_valid=1, m_exc=12, m_bd=1, m_pc=32'h3010.
  - Required: have2handle=1 and m_exc_final=12 combinationally.
  - After the edge: EPC=32'h300C, Cause=32'h8000_0030, SR.EXL=1.
- Interrupt latency and masking:
  - Set SR=32'h0000_0401 via mtc0, then pulse hwint[0] high.
  - Required: have2handle rises exactly SYNC_STAGES+1 edges later on a valid M instruction, m_exc_final=0.
  - With IM cleared, have2handle never rises.
- Interrupt vs exception collision:
  - Pending enabled IP plus m_exc=4 in the same cycle.
  - Required: m_exc_final=0, ExcCode=0.
  - A second exception while EXL=1 gives have2handle=0.
- mtc0 EPC then eret:
  - Cycle n: cp0_we, addr 14, wdata 32'h0000_3100 → epc output = 32'h3100 in cycle n.
  - Cycle n+1: eret → SR.EXL cleared after the edge.
- Dropped write:
  - cp0_we to SR with wdata=0 in the same cycle have2handle=1.
  - Required: SR keeps prior IM/IE, EXL becomes 1.
